// File: rtl/sentry_pob_gen.sv
// Put-ordering buffer for the Sentry commit path.
// Tracks the in-order commit frame across LANES pipes, pops the matching
// resolved-tag source entries, and drains queued network PUTs to the outgoing
// queue only once every older tag has committed.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   src_tag_num/valid     resolved tags, flattened [s][l] (s major)
//   src_tag_clear         combinational pop per source/lane, same cycle
//   put_fifo_*            show-ahead PUT request queue head and pop
//   out_fifo_*            outgoing PUT queue write port and back-pressure
//   frame_din             oldest uncommitted tag number
//   put_released_cnt      total PUTs released, wraps
module sentry_pob_gen #(
    parameter int unsigned LANES       = 4,
    parameter int unsigned NUM_SRC     = 5,
    parameter int unsigned DIN_W       = 32,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned PREFIX_MODE = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SRC*LANES*DIN_W-1:0]   src_tag_num,
    input  logic [NUM_SRC*LANES-1:0]         src_tag_valid,
    output logic [NUM_SRC*LANES-1:0]         src_tag_clear,
    input  logic                             put_fifo_empty,
    input  logic [DIN_W-1:0]                 put_fifo_tag,
    input  logic [DATA_W-1:0]                put_fifo_data,
    output logic                             put_fifo_rd_en,
    output logic [DATA_W-1:0]                out_fifo_data,
    output logic                             out_fifo_wr_en,
    input  logic                             out_fifo_full,
    input  logic                             out_fifo_almost_full,
    output logic [DIN_W-1:0]                 frame_din,
    output logic [31:0]                      put_released_cnt
);

    localparam int unsigned K_W = $clog2(LANES + 1);
    localparam int unsigned NT  = NUM_SRC * LANES;

    logic [LANES-1:0] lane_ok;
    logic [NT-1:0]    sel;
    logic [K_W-1:0]   commit_cnt;
    logic [DIN_W-1:0] age;
    logic             releasable;
    logic             issue;

    // Per-lane match against frame_din+l; the lowest-numbered matching source wins.
    always_comb begin
        lane_ok = '0;
        sel     = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (!lane_ok[l] && src_tag_valid[s*LANES+l] &&
                    (src_tag_num[(s*LANES+l)*DIN_W +: DIN_W] == frame_din + DIN_W'(l))) begin
                    lane_ok[l]         = 1'b1;
                    sel[s*LANES+l]     = 1'b1;
                end
            end
        end
    end

    // Number of lanes committing this cycle: all-or-nothing, or leading run of matches.
    always_comb begin
        logic run;
        commit_cnt = '0;
        run        = 1'b1;
        if (PREFIX_MODE == 0) begin
            if (&lane_ok) begin
                commit_cnt = K_W'(LANES);
            end
        end else begin
            for (int l = 0; l < LANES; l++) begin
                run = run & lane_ok[l];
                if (run) begin
                    commit_cnt = commit_cnt + K_W'(1);
                end
            end
        end
    end

    // Pop only the selected source of each committing lane; silent in reset.
    always_comb begin
        src_tag_clear = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (rst_n && (K_W'(l) < commit_cnt) && sel[s*LANES+l]) begin
                    src_tag_clear[s*LANES+l] = 1'b1;
                end
            end
        end
    end

    // Serial-number compare: head is older than frame_din when the forward distance is
    // non-zero and less than half the tag space, which keeps ordering correct across wrap.
    always_comb begin
        age        = frame_din - put_fifo_tag;
        releasable = (age != '0) && !age[DIN_W-1];
        // A write already in flight consumes the last slot when almost_full is raised.
        issue      = rst_n && !put_fifo_empty && releasable && !out_fifo_full &&
                     !(out_fifo_almost_full && out_fifo_wr_en);
        put_fifo_rd_en = issue;
    end

    // Frame pointer, outgoing write port and release counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_din        <= DIN_W'(1);
            out_fifo_data    <= '0;
            out_fifo_wr_en   <= 1'b0;
            put_released_cnt <= '0;
        end else begin
            frame_din      <= frame_din + DIN_W'(commit_cnt);
            out_fifo_wr_en <= issue;
            if (issue) begin
                out_fifo_data    <= put_fifo_data;
                put_released_cnt <= put_released_cnt + 32'd1;
            end
        end
    end

endmodule
